// File: rtl/uart_frontend_pkg.sv
// Shared types and constants for the UART receive front end.
package uart_frontend_pkg;

  localparam int PRESC_FRAC_W = 4;

  typedef enum logic [1:0] {
    AB_IDLE,
    AB_WAIT_HIGH,
    AB_WAIT_START,
    AB_MEASURE
  } ab_state_t;

endpackage

// File: rtl/uart_glitch_filter.sv
// Two-flop synchroniser followed by a consistency filter: the output only
// follows the input once FILT_LEN consecutive synchronised samples disagree with it.
module uart_glitch_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic toggle
);

  logic [1:0] sync;
  logic [3:0] cnt;
  logic       differ;

  assign differ = (sync[1] != dout);
  // Asserted in the cycle whose clock edge flips dout.
  assign toggle = differ && (cnt == 4'(FILT_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (!differ) begin
        cnt <= '0;
      end else if (toggle) begin
        dout <= ~dout;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// Serial-line front end: glitch filtering, bit-time based break/idle detection
// and an autobaud engine that times a 0x55 sync character.
module uart_rx_frontend
  import uart_frontend_pkg::*;
#(
  parameter int FILT_LEN   = 3,
  parameter int BREAK_BITS = 11,
  parameter int IDLE_BITS  = 10,
  parameter int MANT_W     = 12
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           RxPin,
  output logic                           rxd,
  input  logic [MANT_W+PRESC_FRAC_W-1:0] prescale_in,
  output logic                           break_det,
  output logic                           idle,
  input  logic                           ab_start,
  output logic                           ab_busy,
  output logic                           ab_done,
  output logic                           ab_err,
  output logic [MANT_W+PRESC_FRAC_W-1:0] ab_prescale
);

  localparam int CW     = MANT_W + 3;
  localparam int LOW_W  = $clog2(BREAK_BITS + 1);
  localparam int HIGH_W = $clog2(IDLE_BITS + 1);

  logic              filt_toggle;
  logic              rxd_d;
  logic              rxd_fall;
  logic [MANT_W-1:0] mant;
  logic [MANT_W-1:0] reload;
  logic [MANT_W-1:0] tick_cnt;
  logic              tick;
  logic [LOW_W-1:0]  low_cnt;
  logic [HIGH_W-1:0] high_cnt;
  logic              unused_frac;

  uart_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filter (
    .clk    (Clk),
    .rst    (Rst),
    .din    (RxPin),
    .dout   (rxd),
    .toggle (filt_toggle)
  );

  assign unused_frac = ^prescale_in[PRESC_FRAC_W-1:0];
  assign mant        = prescale_in[MANT_W+PRESC_FRAC_W-1:PRESC_FRAC_W];
  assign reload      = (mant == '0) ? '0 : mant - 1'b1;
  assign tick        = (tick_cnt == '0);
  assign rxd_fall    = rxd_d & ~rxd;

  assign break_det = !rxd && tick && (low_cnt == LOW_W'(BREAK_BITS - 1));
  assign idle      = rxd && (high_cnt == HIGH_W'(IDLE_BITS));

  // Reloading on the filter toggle aligns bit ticks to the first cycle of the new level.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rxd_d    <= 1'b1;
      tick_cnt <= '0;
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      rxd_d <= rxd;
      if (filt_toggle || tick) tick_cnt <= reload;
      else                     tick_cnt <= tick_cnt - 1'b1;
      if (rxd)                                            low_cnt <= '0;
      else if (tick && low_cnt != LOW_W'(BREAK_BITS))     low_cnt <= low_cnt + 1'b1;
      if (!rxd)                                           high_cnt <= '0;
      else if (tick && high_cnt != HIGH_W'(IDLE_BITS))    high_cnt <= high_cnt + 1'b1;
    end
  end

  ab_state_t     state, state_nx;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] cyc_inc;
  logic [1:0]    edge_cnt;
  logic          cyc_max;
  logic          last_edge;
  logic          cyc_clr;
  logic          done_nx;
  logic          err_nx;

  assign cyc_inc   = cyc_cnt + 1'b1;
  assign cyc_max   = &cyc_cnt;
  assign last_edge = rxd_fall && (edge_cnt == 2'd3);
  assign ab_busy   = (state != AB_IDLE);

  always_comb begin
    state_nx = state;
    cyc_clr  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      AB_IDLE: begin
        if (ab_start) begin
          state_nx = AB_WAIT_HIGH;
          cyc_clr  = 1'b1;
        end
      end
      AB_WAIT_HIGH, AB_WAIT_START: begin
        if (ab_start) begin
          err_nx   = 1'b1;
          state_nx = AB_WAIT_HIGH;
          cyc_clr  = 1'b1;
        end else if (cyc_max) begin
          err_nx   = 1'b1;
          state_nx = AB_IDLE;
        end else if (state == AB_WAIT_HIGH && rxd) begin
          state_nx = AB_WAIT_START;
          cyc_clr  = 1'b1;
        end else if (state == AB_WAIT_START && rxd_fall) begin
          state_nx = AB_MEASURE;
          cyc_clr  = 1'b1;
        end
      end
      AB_MEASURE: begin
        // The completing edge outranks a coincident ab_start.
        if (last_edge && !cyc_max) begin
          done_nx  = 1'b1;
          state_nx = AB_IDLE;
        end else if (ab_start) begin
          err_nx   = 1'b1;
          state_nx = AB_WAIT_HIGH;
          cyc_clr  = 1'b1;
        end else if (break_det || cyc_max) begin
          err_nx   = 1'b1;
          state_nx = AB_IDLE;
        end
      end
      default: state_nx = AB_IDLE;
    endcase
  end

  // Eight bit times divided by 8 in Q.4 is simply the cycle count times two.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= AB_IDLE;
      cyc_cnt     <= '0;
      edge_cnt    <= '0;
      ab_done     <= 1'b0;
      ab_err      <= 1'b0;
      ab_prescale <= '0;
    end else begin
      state   <= state_nx;
      ab_done <= done_nx;
      ab_err  <= err_nx;
      if (cyc_clr || state_nx == AB_IDLE) cyc_cnt <= '0;
      else                                cyc_cnt <= cyc_inc;
      if (cyc_clr)                              edge_cnt <= '0;
      else if (state == AB_MEASURE && rxd_fall) edge_cnt <= edge_cnt + 1'b1;
      if (done_nx) ab_prescale <= {cyc_inc, 1'b0};
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed checks plus a scoreboard
// of expected autobaud prescale values popped on every ab_done pulse.
module tb_uart_rx_frontend;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        RxPin;
  logic        ab_start;
  logic [15:0] prescale_in;
  logic        rxd;
  logic        break_det;
  logic        idle;
  logic        ab_busy;
  logic        ab_done;
  logic        ab_err;
  logic [15:0] ab_prescale;

  int compared   = 0;
  int mismatched = 0;
  int break_cnt  = 0;
  int done_cnt   = 0;
  int err_cnt    = 0;
  logic [15:0] exp_q[$];

  uart_rx_frontend #(
    .FILT_LEN(3), .BREAK_BITS(11), .IDLE_BITS(10), .MANT_W(12)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .RxPin       (RxPin),
    .rxd         (rxd),
    .prescale_in (prescale_in),
    .break_det   (break_det),
    .idle        (idle),
    .ab_start    (ab_start),
    .ab_busy     (ab_busy),
    .ab_done     (ab_done),
    .ab_err      (ab_err),
    .ab_prescale (ab_prescale)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold the pin at a level for a number of cycles; called at a falling clock edge.
  task automatic applyStimulus(input logic level, input int cycles);
    RxPin = level;
    repeat (cycles) @(negedge Clk);
  endtask

  task automatic pulse_start();
    ab_start = 1'b1;
    @(negedge Clk);
    ab_start = 1'b0;
  endtask

  // First nbits of a 0x55 frame (start, LSB-first data, stop) at cpb_x2/2 cycles per bit.
  task automatic send_frame(input int cpb_x2, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      int dur;
      dur = ((k + 1) * cpb_x2) / 2 - (k * cpb_x2) / 2;
      applyStimulus((k == 9) ? 1'b1 : 1'(k % 2), dur);
    end
  endtask

  task automatic autobaud(input int cpb_x2, input logic [15:0] exp);
    int d0;
    d0 = done_cnt;
    pulse_start();
    checkOutput("busy_after_start", 32'(ab_busy), 32'd1);
    exp_q.push_back(exp);
    send_frame(cpb_x2, 10);
    applyStimulus(1'b1, 20);
    checkOutput("done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("busy_after_done", 32'(ab_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_rxd"}, 32'(rxd), 32'd1);
    checkOutput({tag, "_idle"}, 32'(idle), 32'd0);
    checkOutput({tag, "_break"}, 32'(break_det), 32'd0);
    checkOutput({tag, "_busy"}, 32'(ab_busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(ab_done), 32'd0);
    checkOutput({tag, "_err"}, 32'(ab_err), 32'd0);
    checkOutput({tag, "_prescale"}, 32'(ab_prescale), 32'd0);
  endtask

  // Pulse monitor and scoreboard consumer.
  always @(negedge Clk) begin
    if (break_det === 1'b1) break_cnt++;
    if (ab_err === 1'b1) err_cnt++;
    if (ab_done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) checkOutput("done_without_expectation", 32'(exp_q.size()), 32'd1);
      else checkOutput("ab_prescale", 32'(ab_prescale), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int saw_low, lat, b0, e0, d0, n;
    Rst = 1'b1;
    RxPin = 1'b1;
    ab_start = 1'b0;
    prescale_in = 16'h0100;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Rst = 1'b0;
    applyStimulus(1'b1, 20);

    $display("[TB] glitch filter");
    saw_low = 0;
    RxPin = 1'b0;
    repeat (2) begin @(negedge Clk); if (rxd === 1'b0) saw_low = 1; end
    RxPin = 1'b1;
    repeat (10) begin @(negedge Clk); if (rxd === 1'b0) saw_low = 1; end
    checkOutput("glitch_2cyc", 32'(saw_low), 32'd0);
    RxPin = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (i == 3) RxPin = 1'b1;
      if (rxd === 1'b0 && lat == 0) lat = i;
    end
    checkOutput("filt_latency", 32'(lat), 32'd5);
    applyStimulus(1'b1, 20);

    $display("[TB] break detection");
    b0 = break_cnt;
    applyStimulus(1'b0, 176);
    applyStimulus(1'b1, 20);
    checkOutput("break_176", 32'(break_cnt - b0), 32'd1);
    b0 = break_cnt;
    applyStimulus(1'b0, 400);
    applyStimulus(1'b1, 20);
    checkOutput("break_400", 32'(break_cnt - b0), 32'd1);

    $display("[TB] idle detection");
    send_frame(320, 10);
    checkOutput("idle_early", 32'(idle), 32'd0);
    applyStimulus(1'b1, 20);
    checkOutput("idle_set", 32'(idle), 32'd1);
    RxPin = 1'b0;
    for (int k = 0; k < 20 && rxd !== 1'b0; k++) @(negedge Clk);
    checkOutput("idle_rxd_fell", 32'(rxd), 32'd0);
    checkOutput("idle_drop", 32'(idle), 32'd0);
    applyStimulus(1'b1, 30);

    $display("[TB] autobaud");
    autobaud(320, 16'h0A00);
    autobaud(201, 16'h0648);

    $display("[TB] autobaud timeout");
    e0 = err_cnt;
    pulse_start();
    n = 0;
    while (err_cnt == e0 && n < 40000) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("timeout_err", 32'(err_cnt - e0), 32'd1);
    checkOutput("timeout_window", 32'(n >= 32760 && n <= 32780), 32'd1);
    checkOutput("timeout_busy", 32'(ab_busy), 32'd0);

    $display("[TB] autobaud abort");
    e0 = err_cnt;
    d0 = done_cnt;
    pulse_start();
    send_frame(320, 4);
    pulse_start();
    applyStimulus(1'b1, 5);
    checkOutput("abort_err", 32'(err_cnt - e0), 32'd1);
    checkOutput("abort_busy", 32'(ab_busy), 32'd1);
    checkOutput("abort_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.push_back(16'h0A00);
    send_frame(320, 10);
    applyStimulus(1'b1, 20);
    checkOutput("abort_remeasure_done", 32'(done_cnt - d0), 32'd1);
    checkOutput("abort_single_err", 32'(err_cnt - e0), 32'd1);

    $display("[TB] reset mid-measure");
    pulse_start();
    send_frame(320, 3);
    Rst = 1'b1;
    @(negedge Clk);
    check_reset_outputs("midrst");
    Rst = 1'b0;
    applyStimulus(1'b1, 40);
    d0 = done_cnt;
    send_frame(320, 10);
    applyStimulus(1'b1, 20);
    checkOutput("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    checkOutput("midrst_busy", 32'(ab_busy), 32'd0);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
